// File: rtl/pwm_bank_shadowed.sv
// Multi-channel PWM bank with shadowed top/duty registers that load together at a period boundary.
// Optional up/down (centre-aligned) counting is built only when PWM_CENTER_ALIGN_EN is defined.
module pwm_bank_shadowed #(
    parameter int NUM_CH  = 16,
    parameter int PRESC_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [6:0]        wr_addr,
    input  logic [7:0]        wr_data,
    output logic [NUM_CH-1:0] out,
    output logic              period_tick
);

    localparam int NB = NUM_CH / 8;
    localparam logic [PRESC_W-1:0] PRE_ONE = PRESC_W'(1);

    logic [NUM_CH-1:0]  en_out_q, en_out_d;
    logic [NUM_CH-1:0]  en_pwm_q, en_pwm_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]         top_sh_q, top_sh_d;
    logic [7:0]         top_act_q;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         duty_sh_q  [NUM_CH];
    logic [7:0]         duty_sh_d  [NUM_CH];
    logic [7:0]         duty_act_q [NUM_CH];
    logic [NUM_CH-1:0]  out_q, out_d;
    logic               adv;
    logic               boundary;

`ifdef PWM_CENTER_ALIGN_EN
    logic mode_sh_q, mode_sh_d;
    logic mode_act_q;
    logic dir_q, dir_d;
`endif

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        en_out_d  = en_out_q;
        en_pwm_d  = en_pwm_q;
        presc_d   = presc_q;
        top_sh_d  = top_sh_q;
        duty_sh_d = duty_sh_q;
`ifdef PWM_CENTER_ALIGN_EN
        mode_sh_d = mode_sh_q;
`endif
        if (wr_en) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_addr == 7'(k))     en_out_d[8*k +: 8] = wr_data;
                if (wr_addr == 7'(4 + k)) en_pwm_d[8*k +: 8] = wr_data;
            end
            if (wr_addr == 7'h08) presc_d  = wr_data[PRESC_W-1:0];
            if (wr_addr == 7'h09) top_sh_d = wr_data;
`ifdef PWM_CENTER_ALIGN_EN
            if (wr_addr == 7'h0A) mode_sh_d = wr_data[0];
`endif
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_addr == 7'(16 + c)) duty_sh_d[c] = wr_data;
            end
        end
    end

    // A prescale shrunk below the running count still advances on the next cycle.
    always_comb begin
        adv       = (pre_cnt_q >= presc_q);
        pre_cnt_d = adv ? '0 : pre_cnt_q + PRE_ONE;
    end

    always_comb begin
        cnt_d    = cnt_q;
        boundary = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        dir_d    = dir_q;
        if (adv && mode_act_q) begin
            if (top_act_q == 8'd0) begin
                boundary = 1'b1;
            end else if (dir_q || (cnt_q == top_act_q)) begin
                cnt_d    = cnt_q - 8'd1;
                dir_d    = (cnt_q != 8'd1);
                boundary = (cnt_q == 8'd1);
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else if (adv) begin
            boundary = (cnt_q == top_act_q);
            cnt_d    = boundary ? 8'd0 : cnt_q + 8'd1;
        end
`else
        if (adv) begin
            boundary = (cnt_q == top_act_q);
            cnt_d    = boundary ? 8'd0 : cnt_q + 8'd1;
        end
`endif
    end

    // Enables use their post-write value so they reach the pins one clock after the strobe.
    always_comb begin
        out_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            out_d[c] = en_out_d[c] & (~en_pwm_d[c] | (cnt_q < duty_act_q[c]));
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_out_q  <= '0;
            en_pwm_q  <= '0;
            presc_q   <= '0;
            pre_cnt_q <= '0;
            top_sh_q  <= 8'hFF;
            top_act_q <= 8'hFF;
            cnt_q     <= '0;
            out_q     <= '0;
            // NOTE: the duty arrays are plain flops with defined reset values, not RAM, so they are reset.
            for (int c = 0; c < NUM_CH; c++) begin
                duty_sh_q[c]  <= '0;
                duty_act_q[c] <= '0;
            end
`ifdef PWM_CENTER_ALIGN_EN
            mode_sh_q  <= 1'b0;
            mode_act_q <= 1'b0;
            dir_q      <= 1'b0;
`endif
        end else begin
            en_out_q  <= en_out_d;
            en_pwm_q  <= en_pwm_d;
            presc_q   <= presc_d;
            pre_cnt_q <= pre_cnt_d;
            top_sh_q  <= top_sh_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            for (int c = 0; c < NUM_CH; c++) begin
                duty_sh_q[c] <= duty_sh_d[c];
            end
`ifdef PWM_CENTER_ALIGN_EN
            mode_sh_q <= mode_sh_d;
            dir_q     <= dir_d;
            if (boundary) mode_act_q <= mode_sh_q;
`endif
            if (boundary) begin
                top_act_q <= top_sh_q;
                for (int c = 0; c < NUM_CH; c++) begin
                    duty_act_q[c] <= duty_sh_q[c];
                end
            end
        end
    end

    assign out         = out_q;
    assign period_tick = boundary;

endmodule

// File: tb/tb_pwm_bank_shadowed.sv
// Self-checking bench for pwm_bank_shadowed (default edge-aligned build): an integer-level
// period model is compared every cycle, plus hand-computed period and duty counts.
module tb_pwm_bank_shadowed;

    localparam int NUM_CH  = 16;
    localparam int PRESC_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [6:0]        wr_addr;
    logic [7:0]        wr_data;
    logic [NUM_CH-1:0] out;
    logic              period_tick;

    int total = 0;
    int bad   = 0;

    pwm_bank_shadowed #(.NUM_CH(NUM_CH), .PRESC_W(PRESC_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .out         (out),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: position in the period as plain integers.
    int              m_cnt, m_since, m_presc, m_top_sh, m_top_act;
    int              m_duty_sh  [NUM_CH];
    int              m_duty_act [NUM_CH];
    bit [NUM_CH-1:0] m_en_out, m_en_pwm, m_out;

    task automatic model_reset();
        m_cnt = 0; m_since = 0; m_presc = 0;
        m_top_sh = 255; m_top_act = 255;
        m_en_out = '0; m_en_pwm = '0; m_out = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_duty_sh[c]  = 0;
            m_duty_act[c] = 0;
        end
    endtask

    initial begin : model_compare
        bit              step_now, bnd;
        bit [NUM_CH-1:0] en_o, en_p;
        int              a;
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            step_now = (m_since >= m_presc);
            bnd      = step_now && (m_cnt >= m_top_act);
            check("cycle_out", out, m_out);
            check("cycle_tick", period_tick, bnd);
            if (rst_n) begin
                a    = int'(wr_addr);
                en_o = m_en_out;
                en_p = m_en_pwm;
                if (wr_en && a < NUM_CH / 8) en_o[8*a +: 8] = wr_data;
                if (wr_en && a >= 4 && a < 4 + NUM_CH / 8) en_p[8*(a-4) +: 8] = wr_data;
                for (int c = 0; c < NUM_CH; c++)
                    m_out[c] = en_o[c] && (!en_p[c] || (m_cnt < m_duty_act[c]));
                if (step_now) begin
                    m_since = 0;
                    m_cnt   = bnd ? 0 : m_cnt + 1;
                end else begin
                    m_since++;
                end
                if (bnd) begin
                    m_top_act = m_top_sh;
                    for (int c = 0; c < NUM_CH; c++) m_duty_act[c] = m_duty_sh[c];
                end
                if (wr_en && a == 8) m_presc = int'(wr_data) % (1 << PRESC_W);
                if (wr_en && a == 9) m_top_sh = int'(wr_data);
                if (wr_en && a >= 16 && a < 16 + NUM_CH) m_duty_sh[a-16] = int'(wr_data);
                m_en_out = en_o;
                m_en_pwm = en_p;
            end
        end
    end

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_tick(input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (period_tick !== 1'b1 && n < budget);
        check(name, period_tick, 1'b1);
    endtask

    // Called on a boundary negedge; returns clocks until the next boundary.
    task automatic measure_period(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (period_tick !== 1'b1 && n < budget);
    endtask

    task automatic measure(input int ch, input int cycles, output int highs);
        highs = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (out[ch] === 1'b1) highs++;
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n, h1, h2, h3, h4, h5;
        rst_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        #2 rst_n = 1'b0;
        #1;
        check("t1_reset_out", out, '0);
        check("t1_reset_tick", period_tick, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: free-running default period of 256 clocks
        wait_tick(300, "t1_first_tick");
        measure_period(300, n);
        check("t1_period", n, 256);

        // 2: static enable reaches out[0] one clock after the strobe cycle
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = 7'h00; wr_data = 8'h01;
        @(negedge clk);
        check("t2_out0_during_write", out[0], 1'b0);
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk);
        check("t2_out0_after_write", out[0], 1'b1);
        measure(0, 50, h1);
        check("t2_out0_steady", h1, 50);

        // 3: channel 3 at duty 64 of 256
        wr(7'h00, 8'h09);
        wr(7'h04, 8'h08);
        wr(7'h13, 8'd64);
        wait_tick(300, "t3_load_tick");
        measure(3, 256, h1);
        check("t3_ch3_high", h1, 64);

        // 4: mid-period duty write, then a write on the boundary cycle itself
        fork
            measure(3, 256, h1);
            begin
                repeat (100) @(posedge clk);
                wr(7'h13, 8'd128);
            end
        join
        measure(3, 256, h2);
        fork
            measure(3, 256, h3);
            begin
                repeat (255) @(posedge clk);
                wr(7'h13, 8'd32);
            end
        join
        measure(3, 256, h4);
        measure(3, 256, h5);
        check("t4_same_period", h1, 64);
        check("t4_next_period", h2, 128);
        check("t4_bnd_write_period", h3, 128);
        check("t4_bnd_write_delayed", h4, 128);
        check("t4_bnd_write_applied", h5, 32);

        // 5: top=9, prescale=3 -> 40-clock period; duty above top, then zero duty
        wr(7'h09, 8'd9);
        wr(7'h08, 8'd3);
        wr(7'h10, 8'd10);
        wr(7'h04, 8'h09);
        wait_tick(1100, "t5_load_tick");
        measure_period(100, n);
        check("t5_period", n, 40);
        measure(0, 80, h1);
        check("t5_duty_over_top", h1, 80);
        wr(7'h10, 8'd0);
        wait_tick(100, "t5_zero_tick_a");
        wait_tick(100, "t5_zero_tick_b");
        measure(0, 80, h1);
        check("t5_duty_zero", h1, 0);

        // top=0: every prescaled advance is a boundary
        wr(7'h09, 8'd0);
        wait_tick(100, "t5_top0_tick_a");
        wait_tick(100, "t5_top0_tick_b");
        measure_period(20, n);
        check("t5_top0_period", n, 4);

        // 6: asynchronous reset mid-period clears outputs immediately
        @(negedge clk);
        check("t6_pre_out3", out[3], 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t6_async_out", out, '0);
        check("t6_async_tick", period_tick, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t6_after_release_out", out, '0);
        wait_tick(300, "t6_first_tick");
        measure_period(300, n);
        check("t6_period_restored", n, 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
